mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer_pkg.sv | 57 +++++
 rtl/mem_access_sequencer_rr_arbiter_2.sv | 35 +++
 rtl/mem_access_sequencer.sv | 168 ++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer: size encodings, FSM
// states, the captured-request payload and small decode helpers.
package mem_access_sequencer_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W     = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Request attributes latched at grant (address kept separately, it is sized by ADDR_W)
   typedef struct packed {
      logic              we;
      logic              uns;
      logic [1:0]        size;
      logic [DATA_W-1:0] wdata;
   } req_attr_t;

   // Size legal and naturally aligned
   function automatic logic size_legal(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b1;
         SZ_HALF: return (addr_lo[0] == 1'b0);
         SZ_WORD: return (addr_lo == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Index of the final byte of a transfer
   function automatic logic [1:0] last_idx(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 2'd0;
         SZ_HALF: return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   // Sign- or zero-extend an assembled load result
   function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                  input logic [1:0] size,
                                                  input logic uns);
      case (size)
         SZ_BYTE: return {{24{~uns & raw[7]}},  raw[7:0]};
         SZ_HALF: return {{16{~uns & raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_sequencer_rr_arbiter_2.sv
// Two-way round-robin arbiter. On contention the port not granted last wins;
// core (index 0) is favoured out of reset.
//   req[1:0]  requests (0 core, 1 loader)
//   advance   a grant is being taken this cycle
//   gnt[1:0]  one-hot combinational grant
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic pref_q; // port favoured on contention

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = pref_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Favour the other port after every grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pref_q <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         pref_q <= gnt[0];
      end
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// Arbitrates core and loader load/store requests onto a byte-wide memory
// port, moving one byte per cycle little-endian.
//   c_* / l_*          core / loader request and completion ports
//   mem_addr/we/wdata  registered byte-port drive; mem_rdata combinational read
//   busy, owner        not idle; current grant (0 core, 1 loader)
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic              c_unsigned,
   input  logic [1:0]        c_size,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   output logic              c_done,
   output logic              c_err,
   output logic [31:0]       c_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic              l_unsigned,
   input  logic [1:0]        l_size,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [31:0]       l_wdata,
   output logic              l_done,
   output logic              l_err,
   output logic [31:0]       l_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              owner
);

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   req_attr_t         attr_q, attr_d;
   logic              owner_d;
   logic [31:0]       res_q, res_d;

   logic [ADDR_W-1:0] mem_addr_d;
   logic              mem_we_d;
   logic [7:0]        mem_wdata_d;
   logic              done_d, err_d;
   logic [31:0]       rdata_d;

   logic [1:0]        gnt;
   logic              advance;
   logic [ADDR_W-1:0] win_addr;
   req_attr_t         win_attr;

   assign advance  = (state_q == ST_IDLE) && (c_req || l_req);
   assign win_addr = gnt[1] ? l_addr : c_addr;
   assign win_attr = gnt[1] ?
      req_attr_t'{we: l_we, uns: l_unsigned, size: l_size, wdata: l_wdata} :
      req_attr_t'{we: c_we, uns: c_unsigned, size: c_size, wdata: c_wdata};

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({l_req, c_req}),
      .advance (advance),
      .gnt     (gnt)
   );

   // Next state and next registered outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      attr_d      = attr_q;
      owner_d     = owner;
      res_d       = res_q;
      mem_addr_d  = '0;
      mem_we_d    = 1'b0;
      mem_wdata_d = 8'h00;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = 32'h0;

      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               owner_d = gnt[1];
               addr_d  = win_addr;
               attr_d  = win_attr;
               cnt_d   = 2'd0;
               res_d   = 32'h0;
               if (!size_legal(win_attr.size, win_addr[1:0])) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d     = ST_XFER;
                  mem_addr_d  = win_addr;
                  mem_we_d    = win_attr.we;
                  mem_wdata_d = win_attr.wdata[7:0];
               end
            end
         end

         ST_XFER: begin
            if (!attr_q.we) begin
               res_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
            end
            if (cnt_q == last_idx(attr_q.size)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               rdata_d = attr_q.we ? 32'h0 : load_ext(res_d, attr_q.size, attr_q.uns);
            end else begin
               cnt_d       = cnt_q + 2'd1;
               mem_addr_d  = addr_q + ADDR_W'(cnt_d);
               mem_we_d    = attr_q.we;
               mem_wdata_d = attr_q.wdata[{cnt_d, 3'b000} +: 8];
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; done/err/rdata routed to the owner only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 2'd0;
         addr_q    <= '0;
         attr_q    <= '0;
         res_q     <= 32'h0;
         owner     <= 1'b0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= 8'h00;
         c_done    <= 1'b0;
         c_err     <= 1'b0;
         c_rdata   <= 32'h0;
         l_done    <= 1'b0;
         l_err     <= 1'b0;
         l_rdata   <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         attr_q    <= attr_d;
         res_q     <= res_d;
         owner     <= owner_d;
         busy      <= (state_d != ST_IDLE);
         mem_addr  <= mem_addr_d;
         mem_we    <= mem_we_d;
         mem_wdata <= mem_wdata_d;
         c_done    <= done_d & ~owner_d;
         c_err     <= err_d & ~owner_d;
         c_rdata   <= owner_d ? 32'h0 : rdata_d;
         l_done    <= done_d & owner_d;
         l_err     <= err_d & owner_d;
         l_rdata   <= owner_d ? rdata_d : 32'h0;
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed scenarios followed
// by randomized single and contended transfers against a byte-array model.
module tb_mem_access_sequencer;

   localparam int unsigned AW    = 12;
   localparam int unsigned MSIZE = 4096;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          req_v   [2];
   logic          we_v    [2];
   logic          uns_v   [2];
   logic [1:0]    size_v  [2];
   logic [AW-1:0] addr_v  [2];
   logic [31:0]   wdata_v [2];

   logic          c_done, c_err, l_done, l_err, mem_we, busy, owner;
   logic [31:0]   c_rdata, l_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata;

   logic [7:0] mem     [MSIZE] = '{default: 8'h00};
   logic [7:0] ref_mem [MSIZE] = '{default: 8'h00};
   bit         pref_ldr;  // model: loader wins the next contention

   int n_chk  = 0;
   int n_pass = 0;

   mem_access_sequencer #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(req_v[0]), .c_we(we_v[0]), .c_unsigned(uns_v[0]), .c_size(size_v[0]),
      .c_addr(addr_v[0]), .c_wdata(wdata_v[0]),
      .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
      .l_req(req_v[1]), .l_we(we_v[1]), .l_unsigned(uns_v[1]), .l_size(size_v[1]),
      .l_addr(addr_v[1]), .l_wdata(wdata_v[1]),
      .l_done(l_done), .l_err(l_err), .l_rdata(l_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit legal(input logic [1:0] size, input logic [AW-1:0] addr);
      if (size == 2'd3) return 0;
      return (int'(addr) % nbytes(size)) == 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [AW-1:0] addr, input logic [1:0] size,
                                              input logic uns);
      int n;
      logic [63:0] v, mask;
      n = nbytes(size);
      v = 64'h0;
      for (int k = 0; k < n; k++)
         v = v | (64'(ref_mem[(int'(addr) + k) % MSIZE]) << (8 * k));
      mask = (64'd1 << (8 * n)) - 64'd1;
      if (!uns && v[8*n-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic done_of(input bit p);  return p ? l_done  : c_done;  endfunction
   function automatic logic err_of(input bit p);   return p ? l_err   : c_err;   endfunction
   function automatic logic [31:0] rdata_of(input bit p); return p ? l_rdata : c_rdata; endfunction

   task automatic set_req(input bit p, input logic we, input logic [1:0] size, input logic uns,
                          input logic [AW-1:0] addr, input logic [31:0] wdata);
      we_v[p] = we; size_v[p] = size; uns_v[p] = uns; addr_v[p] = addr; wdata_v[p] = wdata;
      req_v[p] = 1'b1;
   endtask

   // Entered just after a rising edge with the DUT idle and port p's request
   // already high; follows the transfer to its done pulse and retires it.
   task automatic serve(input bit p);
      bit ok, got;
      int n, lat;
      logic [31:0] exp_rd, wd;
      logic [AW-1:0] a;
      ok     = legal(size_v[p], addr_v[p]);
      n      = ok ? nbytes(size_v[p]) : 0;
      exp_rd = (ok && !we_v[p]) ? model_load(addr_v[p], size_v[p], uns_v[p]) : 32'h0;
      a      = addr_v[p];
      wd     = wdata_v[p];
      got = 0; lat = 0;
      @(posedge clk);
      for (int cyc = 1; cyc <= 12 && !got; cyc++) begin
         @(negedge clk);
         if (done_of(p)) begin
            got = 1; lat = cyc;
         end else if (cyc <= n) begin
            chk("xfer_addr", 32'(mem_addr), 32'((int'(a) + cyc - 1) % MSIZE));
            chk("xfer_we", 32'(mem_we), 32'(we_v[p]));
            chk("xfer_owner", 32'(owner), 32'(p));
            if (we_v[p]) chk("xfer_wdata", 32'(mem_wdata), 32'(wd[8*(cyc-1) +: 8]));
         end
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", 32'(lat), 32'(n + 1));
      chk("err", 32'(err_of(p)), 32'(!ok));
      chk("rdata", rdata_of(p), exp_rd);
      chk("other_done", 32'(done_of(!p)), 32'd0);
      chk("done_mem_we", 32'(mem_we), 32'd0);
      if (ok && we_v[p])
         for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % MSIZE] = wd[8*k +: 8];
      pref_ldr = (p == 1'b0);
      @(posedge clk);
      #1;
      req_v[p] = 1'b0;
      chk("done_pulse_width", 32'(done_of(p)), 32'd0);
      for (int k = 0; k < n; k++)
         chk("mem_byte", 32'(mem[(int'(a) + k) % MSIZE]), 32'(ref_mem[(int'(a) + k) % MSIZE]));
   endtask

   // Both ports request in the same idle cycle
   task automatic serve_both();
      bit first;
      first = pref_ldr;
      serve(first);
      serve(!first);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] sz;
      logic [AW-1:0] ad;
      for (int p = 0; p < 2; p++) begin
         req_v[p] = 0; we_v[p] = 0; uns_v[p] = 0; size_v[p] = 0; addr_v[p] = '0; wdata_v[p] = '0;
      end
      pref_ldr = 0;
      rst_n = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_c_done", 32'(c_done), 32'd0);
      chk("rst_l_done", 32'(l_done), 32'd0);
      chk("rst_c_rdata", c_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // idle with no requests
      repeat (2) begin
         @(negedge clk);
         chk("idle_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;

      // contention straight after reset: core first, then loader
      set_req(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
      set_req(1, 1'b0, 2'd0, 1'b1, 12'h011, 32'h0);
      chk("rr_model_core_first", 32'(pref_ldr), 32'd0);
      serve_both();

      // word store, then loads of the stored bytes
      set_req(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hA1B2C3D4); serve(0);
      set_req(0, 1'b0, 2'd0, 1'b0, 12'h013, 32'h0);        serve(0);
      set_req(0, 1'b0, 2'd0, 1'b1, 12'h013, 32'h0);        serve(0);
      set_req(0, 1'b0, 2'd1, 1'b0, 12'h012, 32'h0);        serve(0);

      // contention after a core grant: loader first
      set_req(0, 1'b0, 2'd1, 1'b1, 12'h010, 32'h0);
      set_req(1, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
      chk("rr_model_ldr_first", 32'(pref_ldr), 32'd1);
      serve_both();

      // illegal requests
      set_req(1, 1'b1, 2'd1, 1'b0, 12'h021, 32'h5555); serve(1);
      set_req(0, 1'b0, 2'd3, 1'b0, 12'h020, 32'h0);    serve(0);

      // top of memory
      set_req(1, 1'b1, 2'd2, 1'b0, 12'hFFC, 32'h87654321); serve(1);
      set_req(0, 1'b0, 2'd2, 1'b0, 12'hFFC, 32'h0);        serve(0);

      // reset in the third byte of a word store
      set_req(0, 1'b1, 2'd2, 1'b0, 12'h040, 32'h11223344); serve(0);
      set_req(0, 1'b1, 2'd2, 1'b0, 12'h040, 32'hAABBCCDD);
      @(posedge clk);
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("pre_rst_we", 32'(mem_we), 32'd1);
      chk("pre_rst_addr", 32'(mem_addr), 32'h042);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we", 32'(mem_we), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_addr", 32'(mem_addr), 32'd0);
      ref_mem[12'h040] = 8'hDD;
      ref_mem[12'h041] = 8'hCC;
      pref_ldr = 0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_done", 32'(c_done), 32'd0);
      end
      req_v[0] = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
         chk("rst_mem_bytes", 32'(mem[12'h040 + k]), 32'(ref_mem[12'h040 + k]));

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         bit dual;
         bit p;
         dual = ($urandom_range(0, 3) == 0);
         p    = 1'($urandom_range(0, 1));
         for (int q = 0; q < 2; q++) begin
            if (dual || (q == int'(p))) begin
               sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
               ad = AW'($urandom);
               if (($urandom_range(0, 4) != 0) && (sz != 2'd3))
                  ad = ad & ~AW'(nbytes(sz) - 1);
               set_req(q[0], 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
            end
         end
         if (dual) serve_both();
         else      serve(p);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
